// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-master arbiter in front of a single-port synchronous 32-bit RAM
// Ports:
//   clk, reset (async, active-low)
//   m0_* : master 0 (CPU data port)   req/we/addr/wdata in, gnt/rvalid/rdata out
//   m1_* : master 1 (DMA/text copy)   same set plus m1_lock to hold a burst
//   ram_addr/ram_wdata/ram_we out, ram_rdata in (data one cycle after address)
// Config: define MEM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority to master 0.
module mem_port_arbiter #(
  parameter int AW        = 11,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic          m1_lock,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [31:0]   m0_rdata,
  output logic [31:0]   m1_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic          ram_we,
  input  logic [31:0]   ram_rdata
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam int BW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST - 1);
  state_t        state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          m0_rvalid_q, m1_rvalid_q;
  logic          own0, own1, keep0, keep1;
  assign own0 = state_q == OWN0;
  assign own1 = state_q == OWN1;
  assign m0_gnt = own0 & m0_req;
  assign m1_gnt = own1 & m1_req;
  assign ram_addr  = own0 ? m0_addr : own1 ? m1_addr : '0;
  assign ram_wdata = own0 ? m0_wdata : own1 ? m1_wdata : '0;
  assign ram_we    = (m0_gnt & m0_we) | (m1_gnt & m1_we);
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  // owner 0 yields after every grant whenever master 1 is waiting
  assign keep0 = m0_req & ~m1_req;
`else
  // fixed priority: master 1 can never preempt owner 0
  assign keep0 = m0_req;
`endif
  // owner 1 keeps a locked burst until it has taken MAX_BURST grants in a row
  assign keep1 = m1_req & (~m0_req | (m1_lock & (burst_q < BURST_MAX)));
  always_comb begin
    state_d = own0 ? (keep0 ? OWN0 : m1_req ? OWN1 : IDLE) :
              own1 ? (keep1 ? OWN1 : m0_req ? OWN0 : IDLE) :
                     (m0_req ? OWN0 : m1_req ? OWN1 : IDLE);
    burst_d = (state_d != state_q || state_d == IDLE) ? '0 :
              ((m0_gnt | m1_gnt) && burst_q != BURST_MAX) ? burst_q + BW'(1) : burst_q;
  end
  // rvalid follows the grant of a read, so it stays correct when ownership moves
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      m0_rvalid_q <= m0_gnt & ~m0_we;
      m1_rvalid_q <= m1_gnt & ~m1_we;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with a behavioural sync RAM
module tb_mem_port_arbiter;
  localparam int AW = 11;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [31:0]   m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_we;
  logic [31:0]   m0_rdata, m1_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [31:0]   mem [0:2047];
  int            total = 0;
  int            bad = 0;

  mem_port_arbiter #(.AW(AW), .MAX_BURST(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle;
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    repeat (2) next_cycle();
  endtask

  task automatic test_reset;
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 11'h055; m1_addr = 11'h066; m0_we = 1'b1;
    #2;
    total++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_we} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs got=%b want=00000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_we});
    end
    total++;
    if (ram_addr !== '0) begin bad++; $display("FAIL reset_ram_addr got=%h want=000", ram_addr); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_we} !== 5'b0) begin
      bad++; $display("FAIL reset_clocked got=%b want=00000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_we});
    end
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0;
    reset = 1'b1;
    go_idle();
  endtask

  task automatic test_single_read;
    go_idle();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'h010;
    @(negedge clk);
    total++;
    if (m0_gnt !== 1'b0 || ram_addr !== '0) begin
      bad++; $display("FAIL read_bubble got gnt=%b addr=%h want gnt=0 addr=000", m0_gnt, ram_addr);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (m0_gnt !== 1'b1 || ram_addr !== 11'h010 || ram_we !== 1'b0) begin
      bad++; $display("FAIL read_gnt got gnt=%b addr=%h we=%b want gnt=1 addr=010 we=0", m0_gnt, ram_addr, ram_we);
    end
    next_cycle();
    m0_req = 1'b0;
    @(negedge clk);
    total++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_rvalid !== 1'b0) begin
      bad++; $display("FAIL read_data got rv=%b data=%h m1rv=%b want rv=1 data=deadbeef m1rv=0", m0_rvalid, m0_rdata, m1_rvalid);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (m0_rvalid !== 1'b0) begin bad++; $display("FAIL read_rvalid_once got=%b want=0", m0_rvalid); end
  endtask

  task automatic test_arbitration;
    go_idle();
    m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1; m1_we = 1'b1;
    m0_addr = 11'h190; m1_addr = 11'h1F4; m0_wdata = 32'h0000_0A0A; m1_wdata = 32'h0000_0B0B;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin bad++; $display("FAIL arb_bubble got=%b want=00", {m0_gnt, m1_gnt}); end
    next_cycle();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 6; i++) begin
      logic [1:0] exp;
      exp = (i % 2 == 0) ? 2'b10 : 2'b01;
      @(negedge clk);
      total++;
      if ({m0_gnt, m1_gnt} !== exp) begin bad++; $display("FAIL rr_alternate[%0d] got=%b want=%b", i, {m0_gnt, m1_gnt}, exp); end
      next_cycle();
    end
`else
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL fixed_prio[%0d] got=%b want=10", i, {m0_gnt, m1_gnt}); end
      next_cycle();
    end
    m0_req = 1'b0;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin bad++; $display("FAIL fixed_drop got=%b want=00", {m0_gnt, m1_gnt}); end
    next_cycle();
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin bad++; $display("FAIL fixed_m1_after got=%b want=01", {m0_gnt, m1_gnt}); end
`endif
  endtask

  task automatic test_locked_burst;
    int idx, m1_before, m0_cnt;
    bit m0_seen, exp_rv;
    idx = 0; m1_before = 0; m0_cnt = 0; m0_seen = 1'b0; exp_rv = 1'b0;
    go_idle();
    m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b1; m1_addr = 11'd100; m1_wdata = 32'hA000_0000;
    for (int cyc = 0; cyc < 60 && idx < 20; cyc++) begin
      if (cyc == 1) begin m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'h010; end
      @(negedge clk);
      total++;
      if (ram_we !== m1_gnt) begin bad++; $display("FAIL burst_ram_we[%0d] got=%b want=%b", cyc, ram_we, m1_gnt); end
      if (exp_rv) begin
        total++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
          bad++; $display("FAIL burst_m0_read got rv=%b data=%h want rv=1 data=deadbeef", m0_rvalid, m0_rdata);
        end
      end
      exp_rv = m0_gnt;
      if (m0_gnt) begin
        m0_cnt++; m0_seen = 1'b1;
        total++;
        if (m1_before !== 8) begin bad++; $display("FAIL burst_len got=%0d want=8", m1_before); end
      end
      if (m1_gnt) begin
        if (!m0_seen) m1_before++;
        idx++;
      end
      next_cycle();
      if (m0_seen) m0_req = 1'b0;
      m1_addr = AW'(100 + idx); m1_wdata = 32'hA000_0000 + 32'(idx);
    end
    total++;
    if (idx !== 20) begin bad++; $display("FAIL burst_done got=%0d want=20", idx); end
    total++;
    if (m0_cnt !== 1) begin bad++; $display("FAIL burst_m0_count got=%0d want=1", m0_cnt); end
    m1_req = 1'b0; m1_lock = 1'b0;
    next_cycle();
    total++;
    if (mem[100] !== 32'hA000_0000 || mem[108] !== 32'hA000_0008 || mem[119] !== 32'hA000_0013) begin
      bad++; $display("FAIL burst_mem got=%h %h %h want=a0000000 a0000008 a0000013", mem[100], mem[108], mem[119]);
    end
  endtask

  task automatic test_handover_read;
    go_idle();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 11'h010;
    @(negedge clk);
    next_cycle();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 11'h12C; m0_wdata = 32'h0000_1234;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin bad++; $display("FAIL hand1_gnt got=%b want=01", {m0_gnt, m1_gnt}); end
    next_cycle();
    m1_req = 1'b0;
    @(negedge clk);
    total++;
    if (m0_gnt !== 1'b1 || m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEADBEEF || ram_we !== 1'b1) begin
      bad++; $display("FAIL hand1_rvalid got gnt0=%b rv1=%b data=%h we=%b want 1 1 deadbeef 1", m0_gnt, m1_rvalid, m1_rdata, ram_we);
    end
    next_cycle();
    m0_req = 1'b0;
    @(negedge clk);
    total++;
    if (m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0) begin
      bad++; $display("FAIL hand1_after got rv1=%b rv0=%b want 0 0", m1_rvalid, m0_rvalid);
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    go_idle();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'h010;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 11'h0C8; m1_wdata = 32'h0000_0055;
    next_cycle();
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL hand0_gnt got=%b want=10", {m0_gnt, m1_gnt}); end
    next_cycle();
    m0_req = 1'b0;
    @(negedge clk);
    total++;
    if (m1_gnt !== 1'b1 || m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL hand0_rvalid got gnt1=%b rv0=%b data=%h want 1 1 deadbeef", m1_gnt, m0_rvalid, m0_rdata);
    end
`endif
  endtask

  task automatic test_reset_midread;
    go_idle();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 11'h010;
    next_cycle();
    @(negedge clk);
    total++;
    if (m1_gnt !== 1'b1) begin bad++; $display("FAIL rst_read_gnt got=%b want=1", m1_gnt); end
    next_cycle();
    m1_req = 1'b0; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'h010;
    reset = 1'b0;
    #1;
    total++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_we} !== 5'b0) begin
      bad++; $display("FAIL rst_async got=%b want=00000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_we});
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_we} !== 5'b0) begin
      bad++; $display("FAIL rst_held got=%b want=00000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_we});
    end
    reset = 1'b1;
    #1;
    total++;
    if (m0_gnt !== 1'b0 || m1_rvalid !== 1'b0) begin
      bad++; $display("FAIL rst_bubble got gnt0=%b rv1=%b want 0 0", m0_gnt, m1_rvalid);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (m0_gnt !== 1'b1 || m1_rvalid !== 1'b0) begin
      bad++; $display("FAIL rst_first_gnt got gnt0=%b rv1=%b want 1 0", m0_gnt, m1_rvalid);
    end
    next_cycle();
    m0_req = 1'b0;
    @(negedge clk);
    total++;
    if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0) begin
      bad++; $display("FAIL rst_next_read got rv0=%b rv1=%b want 1 0", m0_rvalid, m1_rvalid);
    end
  endtask

  initial begin
    mem[16] <= 32'hDEADBEEF;
    test_reset();
    test_single_read();
    test_arbitration();
    test_locked_burst();
    test_handover_read();
    test_reset_midread();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 11, RAM word-address width (2K x 32-bit words).
REQ-002 SHALL have parameter MAX_BURST, default 8, maximum consecutive locked grants to master 1 while master 0 waits.
REQ-003 SHALL have port clk  input  1  single clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports m0_req / m1_req  input  1  access request from master 0 (CPU data port) / master 1 (DMA/text-copy engine).
REQ-006 SHALL have ports m0_we / m1_we  input  1  write (1) or read (0) qualifier.
REQ-007 SHALL have ports m0_addr / m1_addr  input  AW  word address.
REQ-008 SHALL have ports m0_wdata / m1_wdata  input  32  write data.
REQ-009 SHALL have port m1_lock  input  1  master 1 requests that its burst be held.
REQ-010 SHALL have ports m0_gnt / m1_gnt  output  1  access accepted this cycle.
REQ-011 SHALL have ports m0_rvalid / m1_rvalid  output  1  read data valid, one cycle after a granted read.
REQ-012 SHALL have ports m0_rdata / m1_rdata  output  32  read data, both driven from ram_rdata.
REQ-013 SHALL have ports ram_addr (AW), ram_wdata (32), ram_we (1)  output  drive the synchronous RAM data port.
REQ-014 SHALL have port ram_rdata  input  32  RAM read data, valid one cycle after the address is presented.

Function
REQ-015 SHALL implement a registered owner FSM with states IDLE, OWN0 and OWN1.
REQ-016 IDLE: SHALL drive no grant; SHALL go to OWN0 if m0_req is high, else to OWN1 if m1_req is high, else stay in IDLE (one-cycle arbitration bubble).
REQ-017 OWNx: SHALL assert mx_gnt = mx_req combinationally; the other master's gnt SHALL be 0.
REQ-018 SHALL drive ram_addr / ram_wdata from the owner's inputs, and ram_we = owner_gnt & owner_we; in IDLE, ram_addr = 0 and ram_we = 0.
REQ-019 SHALL assert mx_rvalid for exactly one cycle, in the cycle after each granted read by master x; rvalid SHALL track the grant, not the owner, so it is correct across an owner switch.
REQ-020 When the owner's req is low: SHALL go to the other OWN state if the other req is high, else to IDLE.
REQ-021 When both reqs are high: owner 0 SHALL hand over to OWN1 after each grant (round-robin, see REQ-028).
REQ-022 When both reqs are high and owner is 1: SHALL stay in OWN1 while m1_lock = 1 and burst_cnt < MAX_BURST-1, otherwise SHALL switch to OWN0.
REQ-023 Handover SHALL go directly between OWN states with no IDLE cycle.
REQ-024 burst_cnt SHALL count consecutive grants to the current owner, clear on every owner change or IDLE, and saturate at MAX_BURST-1.
REQ-025 A master SHALL hold req, we, addr and wdata stable until it sees gnt; the arbiter SHALL NOT latch request fields.

Reset
REQ-026 While reset = 0: state SHALL be IDLE, burst_cnt = 0, and all gnt, rvalid and ram_we = 0, asynchronously.
REQ-027 An in-flight read at reset assertion SHALL be dropped: no rvalid after reset release.

Configuration
REQ-028 With macro MEM_ARB_ROUND_ROBIN_EN defined: arbitration SHALL follow REQ-021/022. Without it (fixed priority): owner 0 SHALL never be preempted by master 1, and REQ-022 SHALL still apply to owner 1.

Verification
REQ-029 Only m0 reads addr 0x010 holding 0xDEADBEEF, from IDLE: gnt at cycle 2, m0_rvalid = 1 with rdata 0xDEADBEEF at cycle 3.
REQ-030 Both req continuously, lock = 0, round-robin: grants alternate m0, m1, m0, m1; no cycle without a grant after the first grant.
REQ-031 m1 locked 20-word write burst, m0 requesting, MAX_BURST = 8: m1 gets 8 grants, m0 gets 1, then m1 resumes; ram_we pulses only on m1 grants.
REQ-032 Fixed priority (macro undefined), both req high: m0 granted every cycle, m1 only after m0_req drops.
REQ-033 Reset asserted one cycle after a granted m1 read: all outputs 0 immediately; no m1_rvalid after release; next grant follows the REQ-016 bubble.
REQ-034 m0 read granted in the cycle of handover to OWN1: m0_rvalid asserted next cycle while m1_gnt = 1.
